key_load_scan_ctrl: RTL and testbench
=====================================

Name: key_load_scan_ctrl

Overview:
- Controller in front of the logic-locked s5378 core.
- Fetches the 128-bit unlock key from an on-chip key store (OTP) over a word-wide request/acknowledge interface and assembles it into a key register.
- Drives the core's key inputs and functional enable.
- Arbitrates the core between functional mode and scan mode: key is wiped before the scan-enable to the core is ever raised, so the scan chain cannot be used to observe a keyed core.

Parameters:
KEY_W, 128, total key width (core key_1..key_128; key_out[0] drives key_1)
WORD_W, 32, key-store read width; KEY_W must be an integer multiple of WORD_W
KEY_WORDS, KEY_W/WORD_W (4), derived; number of reads per load
MAX_RETRY, 2, full-load retries after a fetch error before FAIL
TIMEOUT, 63, cycles mem_req may stay unacknowledged before a fetch error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begin key load (honoured in IDLE and FAIL only)
mem_req  out  1  key-store read request, level
mem_addr  out  clog2(KEY_WORDS)  word index being requested
mem_ack  in  1  single-cycle pulse; mem_rdata/mem_err valid this cycle
mem_rdata  in  WORD_W  read word
mem_err  in  1  read error, qualified by mem_ack
scan_req  in  1  tester request for scan mode, level
test_se_out  out  1  scan enable to core
key_out  out  KEY_W  key to core
key_valid  out  1  key_out holds a complete, error-free key
core_en  out  1  functional enable to core (equals key_valid)
busy  out  1  high in FETCH, SCAN_WIPE, SCAN
fail  out  1  sticky load failure

Behaviour:
- Reset (async): state IDLE. All outputs 0, including key_out, mem_addr, retry count, timer.
- States: IDLE, FETCH, READY, FAIL, SCAN_WIPE, SCAN.
- IDLE:
  - start -> FETCH; mem_req=1, mem_addr=0 in the next cycle.
  - key_out is cleared on entry to FETCH.
- FETCH:
  - mem_req held high until each ack.
  - On mem_ack with mem_err=0: capture mem_rdata into key_out[addr*WORD_W +: WORD_W]. If addr < KEY_WORDS-1, increment addr and keep mem_req high, so back-to-back acks give one word per cycle. Otherwise go to READY.
  - The timer resets on every ack and counts each unacknowledged cycle. When it reaches TIMEOUT, or on mem_ack with mem_err=1, a fetch error occurs.
  - Fetch error, retry count < MAX_RETRY: increment retry count, clear key_out, addr=0, mem_req dropped for exactly one cycle, then re-request.
  - Fetch error, retries exhausted: go to FAIL.
  - mem_ack while mem_req=0 is ignored.
- READY:
  - key_valid=core_en=1 from the cycle after the last ack. Minimum load latency with zero-wait ack: start -> key_valid in KEY_WORDS+2 cycles.
  - start is ignored.
  - Retry count is cleared.
- FAIL: fail=1, key_out=0, mem_req=0. start clears fail and retry count and goes to FETCH.
- Scan arbitration (highest priority; applies in every state):
  - scan_req=1 -> SCAN_WIPE next cycle. In SCAN_WIPE, key_out=0, key_valid=core_en=0, mem_req=0, test_se_out=0.
  - SCAN_WIPE -> SCAN. test_se_out=1 from the second cycle after scan_req rises, and never in the same cycle as a non-zero key_out.
  - SCAN: while scan_req=1, hold. On scan_req=0, test_se_out=0 next cycle and state goes to IDLE. A new start is required to reload.
  - scan_req dropping during SCAN_WIPE still completes SCAN_WIPE -> SCAN -> IDLE.
  - An in-flight fetch is abandoned on scan_req. A late mem_ack is ignored.
  - fail is cleared on scan entry.
- start coincident with scan_req: scan wins; start is dropped.
- key_out changes only in FETCH (word capture or clear), on wipe, on FAIL entry and on reset.

Decomposition:
- Package key_ctrl_pkg:
  - state enum (3-bit encoding).
  - Default KEY_W/WORD_W.
  - Function computing mem_addr width.
- One natural sub-module, key_word_assembler: indexed word-write register of KEY_W bits with synchronous clear and async reset.
- FSM, timer and retry counter stay in the top.

Test Plan:
- Reset mid-FETCH (rst pulse at word 2) -> all outputs 0 immediately; no mem_req until the next start.
- start; key store acks every cycle with words 0x01234567, 0x89ABCDEF, 0xDEADBEEF, 0x0BADF00D -> key_valid high 6 cycles after start; key_out = 0x0BADF00D_DEADBEEF_89ABCDEF_01234567; core_en=1.
- mem_err on word 1 of the first attempt, clean second attempt -> mem_req low for 1 cycle, re-read from addr 0, key_valid set; fail=0.
- No ack ever -> three timeouts of 63 cycles each (initial attempt plus 2 retries) -> fail=1 and key_out=0. Then start with clean acks -> fail=0, key_valid=1.
- In READY, raise scan_req -> cycle+1 key_out=0 and core_en=0; cycle+2 test_se_out=1. Drop scan_req -> test_se_out=0 next cycle, state IDLE, key_valid remains 0.
- scan_req during FETCH with a pending ack on the following cycle -> ack ignored, key_out stays 0, mem_req=0, test_se_out=1 two cycles after scan_req.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared types and sizing helpers for the s5378 key-load / scan-arbitration controller.
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_READY     = 3'd2,
        ST_FAIL      = 3'd3,
        ST_SCAN_WIPE = 3'd4,
        ST_SCAN      = 3'd5
    } state_t;

    localparam int DEF_KEY_W  = 128;
    localparam int DEF_WORD_W = 32;

    // A single-word key still needs a 1-bit address port.
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/key_word_assembler.sv
// Key register built from WORD_W-wide slots, written one indexed word at a time.
module key_word_assembler
    import key_ctrl_pkg::*;
#(
    parameter int KEY_W  = DEF_KEY_W,
    parameter int WORD_W = DEF_WORD_W,
    localparam int KEY_WORDS = KEY_W / WORD_W,
    localparam int AW        = addr_width(KEY_W / WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    output logic [KEY_W-1:0]  key
);

    logic [WORD_W-1:0] word_reg [KEY_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < KEY_WORDS; gi++) begin : g_word
            // Clear wins over a coincident write so a wipe can never leave a stale word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg[gi] <= '0;
                end else if (clr) begin
                    word_reg[gi] <= '0;
                end else if (wr_en && (wr_idx == AW'(gi))) begin
                    word_reg[gi] <= wr_data;
                end
            end

            assign key[gi*WORD_W +: WORD_W] = word_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/key_load_scan_ctrl.sv
// Loads the unlock key from OTP into the locked core and keeps the key wiped whenever scan is enabled.
module key_load_scan_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int KEY_W     = DEF_KEY_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 63,
    localparam int KEY_WORDS = KEY_W / WORD_W,
    localparam int AW        = addr_width(KEY_W / WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_err,
    input  logic              scan_req,
    output logic              test_se_out,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              core_en,
    output logic              busy,
    output logic              fail
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic          gap_reg, gap_next;
    logic          key_clr;
    logic          key_wr;
    logic          ack_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            timer_reg <= '0;
            retry_reg <= '0;
            gap_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            timer_reg <= timer_next;
            retry_reg <= retry_next;
            gap_reg   <= gap_next;
        end
    end

    // Acks arriving while the request is down (gap cycle, after abandon) are not ours.
    assign ack_ok = mem_ack && mem_req;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        gap_next   = 1'b0;
        key_clr    = 1'b0;
        key_wr     = 1'b0;

        if (scan_req && (state_reg != ST_SCAN_WIPE) && (state_reg != ST_SCAN)) begin
            state_next = ST_SCAN_WIPE;
            key_clr    = 1'b1;
            addr_next  = '0;
            timer_next = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_FETCH;
                        key_clr    = 1'b1;
                        addr_next  = '0;
                        timer_next = '0;
                    end
                end

                ST_FETCH: begin
                    if (mem_req) begin
                        if (ack_ok && !mem_err) begin
                            key_wr     = 1'b1;
                            timer_next = '0;
                            if (addr_reg == AW'(KEY_WORDS - 1)) begin
                                state_next = ST_READY;
                                addr_next  = '0;
                            end else begin
                                addr_next = addr_reg + 1'b1;
                            end
                        end else if (ack_ok || (timer_reg == TW'(TIMEOUT - 1))) begin
                            // Fetch error: restart the whole load, or give up.
                            key_clr    = 1'b1;
                            addr_next  = '0;
                            timer_next = '0;
                            if (retry_reg < RW'(MAX_RETRY)) begin
                                retry_next = retry_reg + 1'b1;
                                gap_next   = 1'b1;
                            end else begin
                                state_next = ST_FAIL;
                            end
                        end else begin
                            timer_next = timer_reg + 1'b1;
                        end
                    end
                end

                ST_READY: begin
                    retry_next = '0;
                end

                ST_FAIL: begin
                    if (start) begin
                        state_next = ST_FETCH;
                        key_clr    = 1'b1;
                        addr_next  = '0;
                        timer_next = '0;
                        retry_next = '0;
                    end
                end

                ST_SCAN_WIPE: begin
                    state_next = ST_SCAN;
                end

                ST_SCAN: begin
                    if (!scan_req) begin
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    key_clr    = 1'b1;
                    addr_next  = '0;
                    timer_next = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

    key_word_assembler #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W)
    ) u_assembler (
        .clk     (clk),
        .rst     (rst),
        .clr     (key_clr),
        .wr_en   (key_wr),
        .wr_idx  (addr_reg),
        .wr_data (mem_rdata),
        .key     (key_out)
    );

    assign mem_req     = (state_reg == ST_FETCH) && !gap_reg;
    assign mem_addr    = addr_reg;
    assign key_valid   = (state_reg == ST_READY);
    assign core_en     = key_valid;
    assign test_se_out = (state_reg == ST_SCAN);
    assign fail        = (state_reg == ST_FAIL);
    assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_SCAN_WIPE)
                       || (state_reg == ST_SCAN);

endmodule

// File: tb/tb_key_load_scan_ctrl.sv
// Directed bench for key_load_scan_ctrl: key load, retry, timeout/fail, scan wipe ordering.
module tb_key_load_scan_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mem_req;
    logic [1:0]   mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = 32'h0;
    logic         mem_err = 1'b0;
    logic         scan_req = 1'b0;
    logic         test_se_out;
    logic [127:0] key_out;
    logic         key_valid;
    logic         core_en;
    logic         busy;
    logic         fail;

    int checks = 0;
    int passed = 0;
    bit ack_mode = 1'b0;
    bit err_once = 1'b0;
    int err_addr = 0;
    int k;

    logic [31:0] words [4];
    localparam logic [127:0] KEY_EXP = 128'h0BADF00D_DEADBEEF_89ABCDEF_01234567;

    key_load_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .scan_req    (scan_req),
        .test_se_out (test_se_out),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .core_en     (core_en),
        .busy        (busy),
        .fail        (fail)
    );

    always #5 clk = ~clk;

    // One clock; afterwards a zero-wait key store answers any request within the same cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        if (ack_mode && mem_req) begin
            mem_ack   = 1'b1;
            mem_rdata = words[mem_addr];
            if (err_once && (int'(mem_addr) == err_addr)) begin
                mem_err  = 1'b1;
                err_once = 1'b0;
            end
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chkk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        words[0] = 32'h01234567;
        words[1] = 32'h89ABCDEF;
        words[2] = 32'hDEADBEEF;
        words[3] = 32'h0BADF00D;

        // Reset state
        tick();
        tick();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_key_valid", key_valid, 1'b0);
        chk1("rst_test_se", test_se_out, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_fail", fail, 1'b0);
        chkk("rst_key_out", key_out, 128'h0);
        chki("rst_mem_addr", int'(mem_addr), 0);
        rst = 1'b0;
        tick();
        $display("reset released");

        // Asynchronous reset while word 2 is being requested
        ack_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chki("midfetch_addr", int'(mem_addr), 2);
        chkk("midfetch_key_partial", key_out, {64'h0, 32'h89ABCDEF, 32'h01234567});
        #2 rst = 1'b1;
        #1;
        chk1("async_rst_mem_req", mem_req, 1'b0);
        chkk("async_rst_key_out", key_out, 128'h0);
        chki("async_rst_mem_addr", int'(mem_addr), 0);
        chk1("async_rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk1("post_rst_no_req", mem_req, 1'b0);
        $display("reset mid-fetch done");

        // Clean load, one word per cycle; start cycle counts as cycle 1 of 6
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("load_req", mem_req, 1'b1);
        chki("load_addr0", int'(mem_addr), 0);
        tick();
        tick();
        tick();
        chk1("load_not_yet_valid", key_valid, 1'b0);
        tick();
        chk1("load_key_valid", key_valid, 1'b1);
        chk1("load_core_en", core_en, 1'b1);
        chkk("load_key_out", key_out, KEY_EXP);
        chk1("load_req_dropped", mem_req, 1'b0);
        chk1("load_busy", busy, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk1("ready_start_ignored_valid", key_valid, 1'b1);
        chk1("ready_start_ignored_req", mem_req, 1'b0);
        $display("clean load key=%h", key_out);

        // Scan entry from READY
        scan_req = 1'b1;
        tick();
        chkk("scan_wipe_key", key_out, 128'h0);
        chk1("scan_wipe_core_en", core_en, 1'b0);
        chk1("scan_wipe_se", test_se_out, 1'b0);
        chk1("scan_wipe_busy", busy, 1'b1);
        tick();
        chk1("scan_se_high", test_se_out, 1'b1);
        chkk("scan_key_zero", key_out, 128'h0);
        scan_req = 1'b0;
        tick();
        chk1("scan_exit_se", test_se_out, 1'b0);
        chk1("scan_exit_busy", busy, 1'b0);
        tick();
        chk1("scan_exit_no_valid", key_valid, 1'b0);
        chk1("scan_exit_no_req", mem_req, 1'b0);
        $display("scan from ready done");

        // Error on word 1 of the first attempt, clean second attempt
        err_once = 1'b1;
        err_addr = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chki("err_at_addr1", int'(mem_addr), 1);
        tick();
        chk1("err_gap_req_low", mem_req, 1'b0);
        chkk("err_key_cleared", key_out, 128'h0);
        tick();
        chk1("err_rereq", mem_req, 1'b1);
        chki("err_rereq_addr0", int'(mem_addr), 0);
        repeat (4) tick();
        chk1("err_retry_valid", key_valid, 1'b1);
        chkk("err_retry_key", key_out, KEY_EXP);
        chk1("err_retry_no_fail", fail, 1'b0);
        $display("retry after mem_err done");

        // scan_req dropped during SCAN_WIPE still passes through SCAN
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        chk1("short_scan_wipe_se", test_se_out, 1'b0);
        tick();
        chk1("short_scan_se", test_se_out, 1'b1);
        tick();
        chk1("short_scan_exit_se", test_se_out, 1'b0);
        chk1("short_scan_idle", busy, 1'b0);
        $display("short scan pulse done");

        // No ack: 3 x 63-cycle timeouts with two 1-cycle gaps -> FAIL in cycle 192
        ack_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        while ((fail !== 1'b1) && (k < 400)) begin
            tick();
            k = k + 1;
        end
        chki("timeout_fail_cycle", k, 192);
        chk1("timeout_fail", fail, 1'b1);
        chkk("timeout_key_zero", key_out, 128'h0);
        chk1("timeout_no_req", mem_req, 1'b0);
        $display("timeout fail after %0d cycles", k);

        ack_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("recover_fail_clear", fail, 1'b0);
        chk1("recover_req", mem_req, 1'b1);
        repeat (4) tick();
        chk1("recover_valid", key_valid, 1'b1);
        chkk("recover_key", key_out, KEY_EXP);
        $display("recovery load done");

        scan_req = 1'b1;
        tick();
        tick();
        scan_req = 1'b0;
        tick();

        // Scan during fetch with a late ack
        ack_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("abandon_req", mem_req, 1'b1);
        scan_req = 1'b1;
        tick();
        chk1("abandon_req_low", mem_req, 1'b0);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        chkk("abandon_late_ack_key", key_out, 128'h0);
        chk1("abandon_se", test_se_out, 1'b1);
        scan_req = 1'b0;
        tick();
        chk1("abandon_exit_se", test_se_out, 1'b0);
        chk1("abandon_no_valid", key_valid, 1'b0);
        $display("abandoned fetch done");

        // start coincident with scan_req: scan wins, start dropped
        start = 1'b1;
        scan_req = 1'b1;
        tick();
        start = 1'b0;
        chk1("coincident_busy", busy, 1'b1);
        chk1("coincident_no_req", mem_req, 1'b0);
        scan_req = 1'b0;
        tick();
        tick();
        chk1("coincident_idle", busy, 1'b0);
        chk1("coincident_start_dropped", mem_req, 1'b0);
        $display("coincident start/scan done");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
